disp_scan_drv: RTL and testbench

- Downstream consumer of the game FSM's eight 6-bit display codes (d1..d8) and the p1_win/p2_win flags.
- Time-multiplexes the codes onto an 8-digit common-anode seven-segment bank, with registered, ghost-free outputs.
- Blinks the whole bank while either win flag is high.
- Snapshots all eight codes once per scan frame so a frame never mixes old and new text.

---
 rtl/disp_pkg.sv | 26 ++
 rtl/seg7_glyph.sv | 24 ++
 rtl/disp_scan_drv.sv | 133 +++++++++++++
 tb/tb_disp_scan_drv.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment encodings are active-low {dp,g,f,e,d,c,b,a}.
package disp_pkg;

   typedef logic [7:0] seg_t;

   typedef enum logic {
      PH_VISIBLE = 1'b0,
      PH_HIDDEN  = 1'b1
   } phase_t;

   localparam logic [5:0] CODE_DASH = 6'b111111;
   localparam seg_t       SEG_OFF   = 8'hFF;
   localparam seg_t       SEG_DASH  = 8'hBF;

   // Indexed by code[4:1]; 6 doubles as G, letters A..F render P,b,c,S,E,U.
   localparam seg_t GLYPH_TBL [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h8C, 8'h83, 8'hA7, 8'h92, 8'h86, 8'hC1
   };

   function automatic logic [7:0] anode_sel(input logic [2:0] idx);
      return ~(8'h80 >> idx);
   endfunction

endpackage

// File: rtl/seg7_glyph.sv
// Combinational decode of a 6-bit display code into active-low segments.
// Bit 5 forces a dash; bit 0 carries no glyph information.
module seg7_glyph
   import disp_pkg::*;
(
   input  logic [5:0] code,
   output seg_t       seg
);

   logic unused_bit0_s;

   assign unused_bit0_s = code[0];

   // glyph lookup
   always_comb begin
      seg = SEG_DASH;
      if (code[5]) begin
         seg = SEG_DASH;
      end else begin
         seg = GLYPH_TBL[code[4:1]];
      end
   end

endmodule

// File: rtl/disp_scan_drv.sv
// Eight-digit common-anode scan driver with per-frame snapshot, per-slot
// deadtime and whole-bank blinking while a win flag is raised.
module disp_scan_drv
   import disp_pkg::*;
#(
   parameter int SCAN_DIV     = 100000,
   parameter int DEADTIME     = 4,
   parameter int BLINK_FRAMES = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] d1,
   input  logic [5:0] d2,
   input  logic [5:0] d3,
   input  logic [5:0] d4,
   input  logic [5:0] d5,
   input  logic [5:0] d6,
   input  logic [5:0] d7,
   input  logic [5:0] d8,
   input  logic       p1_win,
   input  logic       p2_win,
   output logic [7:0] an,
   output logic [7:0] seg
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PRESC_DEAD = PW'(DEADTIME);
   localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

   logic [PW-1:0] presc_r;
   logic [2:0]    idx_r;
   logic [5:0]    snap_r [8];
   logic [5:0]    d_s    [8];
   phase_t        phase_r, phase_nxt_s;
   logic [FW-1:0] fcnt_r, fcnt_nxt_s;
   logic          tick_s, frame_tick_s, blink_req_s;
   seg_t          glyph_s;
   logic [7:0]    an_nxt_s, an_r;
   seg_t          seg_r;

   assign d_s          = '{d1, d2, d3, d4, d5, d6, d7, d8};
   assign tick_s       = (presc_r == PRESC_LAST);
   assign frame_tick_s = tick_s && (idx_r == 3'd7);
   assign blink_req_s  = p1_win | p2_win;

   // slot prescaler and digit index
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc_r <= '0;
         idx_r   <= 3'd0;
      end else if (tick_s) begin
         presc_r <= '0;
         idx_r   <= idx_r + 3'd1;
      end else begin
         presc_r <= presc_r + PW'(1);
      end
   end

   // frame snapshot so a frame never mixes old and new text
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) snap_r[i] <= CODE_DASH;
      end else if (frame_tick_s) begin
         for (int i = 0; i < 8; i++) snap_r[i] <= d_s[i];
      end
   end

   // blink next-state: dropping the request overrides a coincident frame wrap
   always_comb begin
      phase_nxt_s = phase_r;
      fcnt_nxt_s  = fcnt_r;
      if (!blink_req_s) begin
         phase_nxt_s = PH_VISIBLE;
         fcnt_nxt_s  = '0;
      end else if (frame_tick_s) begin
         if (fcnt_r == FRAME_LAST) begin
            fcnt_nxt_s = '0;
            case (phase_r)
               PH_VISIBLE: phase_nxt_s = PH_HIDDEN;
               PH_HIDDEN:  phase_nxt_s = PH_VISIBLE;
               default:    phase_nxt_s = PH_VISIBLE;
            endcase
         end else begin
            fcnt_nxt_s = fcnt_r + FW'(1);
         end
      end else begin
         fcnt_nxt_s = fcnt_r;
      end
   end

   // blink state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         phase_r <= PH_VISIBLE;
         fcnt_r  <= '0;
      end else begin
         phase_r <= phase_nxt_s;
         fcnt_r  <= fcnt_nxt_s;
      end
   end

   seg7_glyph u_glyph (
      .code (snap_r[idx_r]),
      .seg  (glyph_s)
   );

   // anode select with deadtime and blink blanking
   always_comb begin
      an_nxt_s = SEG_OFF;
      if ((presc_r < PRESC_DEAD) || (phase_r == PH_HIDDEN)) begin
         an_nxt_s = SEG_OFF;
      end else begin
         an_nxt_s = anode_sel(idx_r);
      end
   end

   // registered outputs; seg changes while anodes are dark at slot start
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         an_r  <= SEG_OFF;
         seg_r <= SEG_OFF;
      end else begin
         an_r  <= an_nxt_s;
         seg_r <= glyph_s;
      end
   end

   assign an  = an_r;
   assign seg = seg_r;

endmodule

// File: tb/tb_disp_scan_drv.sv
// Randomized bench for disp_scan_drv against a frame/slot arithmetic model,
// with directed literal checks for scan order, snapshot, blink, reset and glyphs.
module tb_disp_scan_drv;

   localparam int SD = 4;
   localparam int DT = 1;
   localparam int BF = 2;
   localparam int FRAME = 8 * SD;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] dv [8];
   logic       p1_win = 1'b0;
   logic       p2_win = 1'b0;
   logic [7:0] an, seg;

   int n_cmp = 0;
   int n_bad = 0;

   int         mk = 0;
   int         fr = 0;
   logic [5:0] msnap [8];
   logic [7:0] exp_an = 8'hFF;
   logic [7:0] exp_seg = 8'hFF;
   bit         chk_en = 1'b0;

   disp_scan_drv #(.SCAN_DIV(SD), .DEADTIME(DT), .BLINK_FRAMES(BF)) dut (
      .clock (clock), .reset (reset),
      .d1 (dv[0]), .d2 (dv[1]), .d3 (dv[2]), .d4 (dv[3]),
      .d5 (dv[4]), .d6 (dv[5]), .d7 (dv[6]), .d8 (dv[7]),
      .p1_win (p1_win), .p2_win (p2_win),
      .an (an), .seg (seg)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] glyph_ref(input logic [5:0] c);
      if (c[5]) return 8'hBF;
      case (c[4:1])
         4'd0:  return 8'hC0;
         4'd1:  return 8'hF9;
         4'd2:  return 8'hA4;
         4'd3:  return 8'hB0;
         4'd4:  return 8'h99;
         4'd5:  return 8'h92;
         4'd6:  return 8'h82;
         4'd7:  return 8'hF8;
         4'd8:  return 8'h80;
         4'd9:  return 8'h90;
         4'd10: return 8'h8C;
         4'd11: return 8'h83;
         4'd12: return 8'hA7;
         4'd13: return 8'h92;
         4'd14: return 8'h86;
         default: return 8'hC1;
      endcase
   endfunction

   // Model: position in the scan is plain arithmetic on the cycle count since reset.
   initial begin
      int  p, ix;
      bit  hidden;
      for (int i = 0; i < 8; i++) msnap[i] = 6'h3F;
      forever begin
         @(posedge clock or negedge reset);
         if (!reset) begin
            mk = 0;
            fr = 0;
            for (int i = 0; i < 8; i++) msnap[i] = 6'h3F;
            exp_an  = 8'hFF;
            exp_seg = 8'hFF;
         end else begin
            p      = mk % SD;
            ix     = (mk / SD) % 8;
            hidden = ((fr / BF) % 2) == 1;
            exp_an  = (p < DT || hidden) ? 8'hFF : ~(8'h80 >> ix);
            exp_seg = glyph_ref(msnap[ix]);
            if (!(p1_win || p2_win)) fr = 0;
            else if (p == SD - 1 && ix == 7) fr = fr + 1;
            if (p == SD - 1 && ix == 7)
               for (int i = 0; i < 8; i++) msnap[i] = dv[i];
            mk = mk + 1;
         end
      end
   end

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         @(negedge clock);
         if (chk_en) begin
            n_cmp = n_cmp + 1;
            if (an !== exp_an || seg !== exp_seg) begin
               n_bad = n_bad + 1;
               $display("FAIL model k=%0d: got an=%h seg=%h, expected an=%h seg=%h",
                        mk, an, seg, exp_an, exp_seg);
            end
         end
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_cmp = n_cmp + 1;
      if (act !== req) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Returns at the negedge after model edge K (since the last reset release).
   task automatic wait_k(input int k);
      int guard = 0;
      while (mk <= k && guard < 20000) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 20000) begin
         n_cmp = n_cmp + 1;
         n_bad = n_bad + 1;
         $display("FAIL wait_k timeout: at k=%0d, waiting for %0d", mk, k);
      end
   endtask

   logic [5:0] sweep_code [12];
   logic [7:0] sweep_seg  [12];

   initial begin
      int f;
      for (int i = 0; i < 8; i++) dv[i] = 6'h3F;
      for (int v = 0; v < 10; v++) sweep_code[v] = 6'(v * 2);
      sweep_code[10] = 6'b010111;
      sweep_code[11] = 6'b011001;
      sweep_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                    8'h82, 8'hF8, 8'h80, 8'h90, 8'h83, 8'hA7};

      repeat (3) @(negedge clock);
      chk_en = 1'b1;
      check("rst_an", an, 8'hFF);
      check("rst_seg", seg, 8'hFF);
      reset = 1'b1;

      // dashes during the first frame
      wait_k(0);  check("k0_an_dead", an, 8'hFF);
      wait_k(1);  check("k1_an", an, 8'h7F);  check("k1_seg", seg, 8'hBF);

      // U,S,-,1,P,-,-,- captured at end of first frame
      dv = '{6'b011110, 6'b011010, 6'h3F, 6'b000010, 6'b010100, 6'h3F, 6'h3F, 6'h3F};
      wait_k(33); check("f2_d1_an", an, 8'h7F); check("f2_d1_seg", seg, 8'hC1);
      wait_k(37); check("f2_d2_an", an, 8'hBF); check("f2_d2_seg", seg, 8'h92);
      dv[1] = 6'b000100;
      wait_k(41); check("f2_d3_an", an, 8'hDF); check("f2_d3_seg", seg, 8'hBF);
      wait_k(45); check("f2_d4_an", an, 8'hEF); check("f2_d4_seg", seg, 8'hF9);
      wait_k(49); check("f2_d5_an", an, 8'hF7); check("f2_d5_seg", seg, 8'h8C);
      wait_k(69); check("f3_d2_an", an, 8'hBF); check("f3_d2_seg", seg, 8'hA4);

      // glyph sweep through d1
      for (int i = 0; i < 12; i++) begin
         dv[0] = sweep_code[i];
         f = (mk / FRAME + 1) * FRAME;
         wait_k(f + 1);
         check("sweep_an", an, 8'h7F);
         check($sformatf("sweep_seg_%0d", i), seg, sweep_seg[i]);
      end

      // blink: two visible frames, two hidden, repeating
      f = (mk / FRAME + 1) * FRAME;
      wait_k(f - 1);
      p1_win = 1'b1;
      wait_k(f + 33);  check("blink_vis1", an, 8'h7F);
      wait_k(f + 65);  check("blink_hid1", an, 8'hFF);
      wait_k(f + 97);  check("blink_hid2", an, 8'hFF);
      wait_k(f + 129); check("blink_vis2", an, 8'h7F);
      wait_k(f + 6 * FRAME + 10);
      check("blink_hid3", an, 8'hFF);
      p1_win = 1'b0;
      wait_k(f + 6 * FRAME + 13); check("blink_drop_an", an, 8'hEF);

      // asynchronous reset mid-slot
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      check("async_rst_an", an, 8'hFF);
      check("async_rst_seg", seg, 8'hFF);
      @(negedge clock);
      reset = 1'b1;
      wait_k(0); check("post_rst_dead", an, 8'hFF);
      wait_k(1); check("post_rst_an", an, 8'h7F); check("post_rst_seg", seg, 8'hBF);

      // randomized traffic
      for (int c = 0; c < 4000; c++) begin
         @(negedge clock);
         if ($urandom_range(0, 3) == 0) dv[$urandom_range(0, 7)] = 6'($urandom);
         if ($urandom_range(0, 149) == 0) p1_win = ~p1_win;
         if ($urandom_range(0, 149) == 0) p2_win = ~p2_win;
         if ($urandom_range(0, 999) == 0) begin
            #2 reset = 1'b0;
            @(negedge clock);
            reset = 1'b1;
         end
      end

      @(negedge clock);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
